// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and helpers for the instruction-fetch front end.
//   XLEN_MAX   : widest PC the queue entry can hold (the top level's XLEN
//                must not exceed it; narrower PCs are zero-extended).
//   NOP_INSTR  : instruction stored for entries fetched from a bad address.
//   fq_entry_t : one fetch-queue entry {pc, instr, fault}.
//   addr_fault : misaligned or out-of-range check for a fetch address.
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int unsigned XLEN_MAX  = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         instr;
    logic                fault;
  } fq_entry_t;

  // A fetch address is bad when it is not word aligned or when its word
  // index falls beyond the instruction memory.
  function automatic logic addr_fault(input logic [XLEN_MAX-1:0] pc,
                                      input int unsigned         depth);
    return (pc[1:0] != 2'b00) || ((pc >> 2) >= XLEN_MAX'(depth));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Circular FIFO of fq_entry_t between fetch and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (taken when not full, or when a
//                pop happens in the same cycle)
//   push_data  : entry to write
//   pop        : advance the head (ignored when empty)
//   flush      : drop all entries; wins over push and pop
//   head       : entry at the head, straight from storage registers
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// DEPTH must be a power of two (pointers wrap by overflow) and at least 2.
// ---------------------------------------------------------------------------
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t        store_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = store_q[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/ifetch_queue_unit.sv
// ---------------------------------------------------------------------------
// ifetch_queue_unit
// Instruction-fetch front end: PC register, word-addressed instruction
// memory, address-fault tagging and a fetch queue feeding decode through a
// valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   redirect_valid  : single-cycle redirect; flushes the queue, loads
//                     redirect_pc into fetch_pc
//   redirect_pc     : redirect target
//   imem_we/waddr/wdata : synchronous program-load write port
//   out_valid/ready : head-entry handshake to decode
//   out_pc/instr/fault : head entry fields (registered, no path from ready)
//   fetch_pc        : address fetched in the current cycle
//   fq_count        : queue occupancy
// Build option: define IFETCH_FAULT_HALT_EN to stop fetching after the
// first faulting entry is enqueued, until a redirect or reset.
// ---------------------------------------------------------------------------
module ifetch_queue_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned    XLEN       = 64,
  parameter int unsigned    IMEM_DEPTH = 1024,
  parameter int unsigned    FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_instr,
  output logic                          out_fault,
  output logic [XLEN-1:0]               fetch_pc,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0]      imem [IMEM_DEPTH];
  logic [XLEN-1:0]  pc_q;
  fq_entry_t        fetch_entry;
  fq_entry_t        head;
  logic             halted;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;

  // NOTE: the instruction memory has no reset; it is loaded through the
  // write port, and clearing an array this size would cost a reset tree for
  // no functional benefit.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Combinational read of the current fetch address. A same-cycle write to
  // that word lands at the edge, so the read still sees the old word.
  // NOTE: every signal written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fetch_entry       = '0;
    fetch_entry.pc    = XLEN_MAX'(pc_q);
    fetch_entry.fault = addr_fault(XLEN_MAX'(pc_q), IMEM_DEPTH);
    fetch_entry.instr = fetch_entry.fault ? NOP_INSTR : imem[pc_q[AW+1:2]];
  end

  assign pop  = !q_empty && out_ready;
  assign push = !redirect_valid && !halted && (!q_full || pop);

`ifdef IFETCH_FAULT_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             halted <= 1'b0;
    else if (redirect_valid)             halted <= 1'b0;
    else if (push && fetch_entry.fault)  halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  // Redirect wins over sequential advance; without a push the PC holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_pc;
    else if (push)           pc_q <= pc_q + XLEN'(4);
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fetch_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fq_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_valid = !q_empty;
  assign out_pc    = XLEN'(head.pc);
  assign out_instr = head.instr;
  assign out_fault = head.fault;
  assign fetch_pc  = pc_q;

endmodule

// File: tb/tb_ifetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue_unit
// Self-checking bench for ifetch_queue_unit: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based reference
// model. Honours IFETCH_FAULT_HALT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ifetch_queue_unit;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned AW         = $clog2(IMEM_DEPTH);
  localparam int unsigned CW         = $clog2(FQ_DEPTH) + 1;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;
  logic              imem_we = 1'b0;
  logic [AW-1:0]     imem_waddr = '0;
  logic [31:0]       imem_wdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_instr;
  logic              out_fault;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     fq_count;

  ifetch_queue_unit #(
    .XLEN       (XLEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .FQ_DEPTH   (FQ_DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .fetch_pc       (fetch_pc),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_mem [IMEM_DEPTH];
  logic [63:0] m_pc;
  bit          m_halted;

  function automatic bit is_bad(input logic [63:0] pc);
    return ((pc % 64'd4) != 64'd0) || ((pc / 64'd4) >= 64'(IMEM_DEPTH));
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc     = '0;
    m_halted = 0;
  endfunction

  // Advance the model by one clock using the inputs that were applied
  // during the cycle that just ended.
  function automatic void model_step();
    ent_t e;
    bit   deq;
    bit   enq;
    int   sz;
    sz  = mq.size();
    deq = (sz > 0) && out_ready;
    if (redirect_valid) begin
      mq.delete();
      m_pc     = redirect_pc;
      m_halted = 0;
    end else begin
      enq = !m_halted && ((sz < int'(FQ_DEPTH)) || deq);
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.pc    = m_pc;
        e.fault = is_bad(m_pc);
        e.instr = e.fault ? NOP : m_mem[int'(m_pc / 64'd4)];
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
`ifdef IFETCH_FAULT_HALT_EN
        if (e.fault) m_halted = 1;
`endif
      end
    end
    // Writes land after the read of the same cycle.
    if (imem_we) m_mem[imem_waddr] = imem_wdata;
  endfunction

  task automatic compare_all();
    check("fq_count", 64'(fq_count), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("fetch_pc", fetch_pc, m_pc);
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", 64'(out_instr), 64'(mq[0].instr));
      check("out_fault", 64'(out_fault), 64'(mq[0].fault));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  // Asynchronous reset between edges, then release after one edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fetch_pc", fetch_pc, 64'd0);
    check("rst_fq_count", 64'(fq_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic pulse_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // ---- program load while in reset ----
    for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
      logic [31:0] w;
      case (i)
        0:       w = 32'h0055_0533;
        1:       w = 32'h40b5_0533;
        2:       w = 32'h00c5_7533;
        default: w = $urandom;
      endcase
      imem_we    = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = w;
      m_mem[i]   = w;
      @(posedge clk);
      #1;
    end
    imem_we = 1'b0;
    model_reset();

    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_fq_count", 64'(fq_count), 64'd0);
    check("reset_fetch_pc", fetch_pc, 64'd0);
    check("reset_out_pc", out_pc, 64'd0);
    check("reset_out_instr", 64'(out_instr), 64'd0);
    check("reset_out_fault", 64'(out_fault), 64'd0);

    // ---- program sequence, decode always ready ----
    rst       = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("prog0_pc", out_pc, 64'h0);
    check("prog0_instr", 64'(out_instr), 64'h0055_0533);
    cycle();
    check("prog1_pc", out_pc, 64'h4);
    check("prog1_instr", 64'(out_instr), 64'h40b5_0533);
    cycle();
    check("prog2_pc", out_pc, 64'h8);
    check("prog2_instr", 64'(out_instr), 64'h00c5_7533);
    check("prog2_fault", 64'(out_fault), 64'd0);

    // ---- back-pressure from a fresh start ----
    out_ready = 1'b0;
    async_reset();
    for (int i = 0; i < 10; i++) cycle();
    check("bp_count", 64'(fq_count), 64'd4);
    check("bp_fetch_pc", fetch_pc, 64'd16);
    check("bp_head", out_pc, 64'd0);

    // ---- simultaneous enqueue/dequeue at full ----
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("stream_count", 64'(fq_count), 64'd4);
      check("stream_pc", out_pc, 64'(4 * i));
    end

    // ---- redirect while full ----
    out_ready = 1'b0;
    cycle();
    pulse_redirect(64'h40);
    check("redir_count", 64'(fq_count), 64'd0);
    check("redir_valid", 64'(out_valid), 64'd0);
    cycle();
    check("redir_target_pc", out_pc, 64'h40);
    check("redir_target_valid", 64'(out_valid), 64'd1);

    // ---- misaligned fault ----
    pulse_redirect(64'h2);
    cycle();
    check("mis_fault", 64'(out_fault), 64'd1);
    check("mis_instr", 64'(out_instr), 64'(NOP));

    // ---- out-of-range fault ----
    pulse_redirect(64'(4 * IMEM_DEPTH));
    for (int i = 0; i < 6; i++) cycle();
    check("oor_fault", 64'(out_fault), 64'd1);
    check("oor_pc", out_pc, 64'h1000);
`ifdef IFETCH_FAULT_HALT_EN
    check("halt_count", 64'(fq_count), 64'd1);
    check("halt_fetch_pc", fetch_pc, 64'h1004);
`else
    check("seq_fault_count", 64'(fq_count), 64'd4);
    out_ready = 1'b1;
    cycle();
    check("seq_fault_pc", out_pc, 64'h1004);
    check("seq_fault_flag", 64'(out_fault), 64'd1);
`endif

    // ---- randomized traffic ----
    for (int n = 0; n < 600; n++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0:       redirect_pc = 64'($urandom_range(0, IMEM_DEPTH - 1)) << 2;
        1:       redirect_pc = 64'(4 * IMEM_DEPTH - 8);
        2:       redirect_pc = 64'($urandom_range(0, 255)) | 64'd1;
        3:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        4:       redirect_pc = 64'h0;
        default: redirect_pc = 64'($urandom_range(0, 15)) << 2;
      endcase
      imem_we = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) imem_waddr = m_pc[AW+1:2];
      else                            imem_waddr = AW'($urandom_range(0, IMEM_DEPTH - 1));
      imem_wdata = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    imem_we        = 1'b0;

    // ---- reset mid-stream, sequence restarts at 0 ----
    out_ready = 1'b1;
    pulse_redirect(64'h0);
    for (int i = 0; i < 5; i++) cycle();
    async_reset();
    cycle();
    check("restart_pc", out_pc, 64'h0);
    check("restart_instr", 64'(out_instr), 64'(m_mem[0]));
    for (int i = 0; i < 8; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue_unit.md
# ifetch_queue_unit

Parametrised instruction-fetch front end: owns the program counter, reads a word-addressed instruction memory, and buffers fetched instructions in a small FIFO feeding the decode stage through a valid/ready handshake. Supports stall via back-pressure, branch/jump redirect with queue flush, and per-entry address-fault tagging. It replaces the fixed single-register IF/ID path with a decoupled fetch queue.

## Interface
- XLEN, 64, PC/address width
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words
- FQ_DEPTH, 4, fetch queue entries; power of two, at least 2
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  redirect request, single-cycle pulse
- redirect_pc  in  XLEN  redirect target
- imem_we  in  1  instruction memory write enable (program load)
- imem_waddr  in  $clog2(IMEM_DEPTH)  word address for the load
- imem_wdata  in  32  word to store
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- out_pc  out  XLEN  PC of head entry
- out_instr  out  32  instruction of head entry
- out_fault  out  1  head entry fetched from an invalid address
- fetch_pc  out  XLEN  PC to be fetched next
- fq_count  out  $clog2(FQ_DEPTH)+1  current occupancy

## Operation
- Fault check on fetch_pc: fault when fetch_pc[1:0] != 0 or fetch_pc[XLEN-1:2] >= IMEM_DEPTH. On a fault, the stored instruction is NOP (32'h00000013), never X.
- Memory read is combinational at index fetch_pc[$clog2(IMEM_DEPTH)+1:2]. The write port is synchronous. When a write and a read hit the same word in the same cycle, the read returns the old word.
- Enqueue condition: no redirect, not halted, and either fq_count < FQ_DEPTH or a dequeue occurs in the same cycle.
  - On enqueue, {fetch_pc, instr, fault} is written at the tail and fetch_pc <= fetch_pc + 4, modulo 2^XLEN.
  - Without an enqueue, fetch_pc holds.
- Dequeue occurs when out_valid && out_ready. The head advances.
- Enqueue and dequeue in the same cycle leave fq_count unchanged. This also holds when the queue is full.
- Redirect has the highest priority:
  - fq_count <= 0 and both pointers <= 0.
  - fetch_pc <= redirect_pc.
  - Halt is cleared.
  - No enqueue in that cycle. Any dequeue in the same cycle is discarded.
- out_valid = (fq_count != 0). out_pc, out_instr and out_fault come from the head register. The outputs are driven from registers only, with no combinational path from out_ready.
- Pointers wrap modulo FQ_DEPTH.

## Timing
- Reset values:
  - fetch_pc = RESET_PC.
  - fq_count = 0, out_valid = 0.
  - out_pc = 0, out_instr = 0, out_fault = 0; all queue storage resets to 0.
  - Halt flag = 0.
  - Memory contents are not reset.
- Fetch-to-output latency is 1 cycle: an entry enqueued at edge N is visible on the out_* ports after edge N.
- First out_valid appears after the first rising edge following reset deassertion.
- Redirect sampled at edge N: out_valid = 0 after N. Target is enqueued at N+1 and valid after N+1.
- Reset asserted mid-operation clears the queue immediately (asynchronous). fetch_pc returns to RESET_PC.
- With out_ready held 0, the queue fills in FQ_DEPTH cycles. fetch_pc then stalls at RESET_PC + 4*FQ_DEPTH.

## Configuration
- IFETCH_FAULT_HALT_EN defined:
  - Once a faulting entry is enqueued, the halt flag is set and no further enqueues occur.
  - Only a redirect or reset clears the halt flag.
- IFETCH_FAULT_HALT_EN undefined: there is no halt flag. Fetch continues sequentially after a fault, and each faulting entry is tagged individually.

## Structure
- Package ifetch_pkg holds:
  - NOP_INSTR constant (32'h00000013).
  - fq_entry_t typedef {pc, instr, fault}, parameterised by XLEN via package parameter or a localparam width.
  - addr_fault function (pc, depth).
- Sub-module fetch_queue is a circular FIFO of fq_entry_t with push, pop, flush, count, full and empty.
- The top level holds the PC register, memory, fault check, halt flag and enqueue/redirect arbitration.

## Test plan
- Program load: write 32'h00550533, 32'h40b50533, 32'h00c57533 at words 0–2; reset; out_ready = 1. Required response:
  - out_pc sequence 0, 4, 8.
  - Instructions appear in load order on consecutive cycles.
  - out_fault = 0.
- Back-pressure with FQ_DEPTH = 4: hold out_ready = 0 for 10 cycles. Required response:
  - fq_count saturates at 4 and fetch_pc = 16.
  - After out_ready rises, entries drain as pc 0, 4, 8, 12 with no loss or duplication.
- Redirect while full: pulse redirect_valid with redirect_pc = 0x40. Required response:
  - Next cycle fq_count = 0 and out_valid = 0.
  - Following cycle out_pc = 0x40.
- Faults with redirect_pc = 0x2:
  - Required: out_fault = 1 and out_instr = 32'h00000013.
  - With redirect_pc = 4*IMEM_DEPTH = 0x1000, out_fault = 1.
  - Macro defined: exactly one entry is produced, then fetch halts.
  - Macro undefined: sequential faulting entries are produced at pc 0x1000, 0x1004, ...
- Simultaneous enqueue/dequeue at full, with out_ready = 1 while the queue is full: fq_count stays 4 and one entry per cycle streams out.
- Reset mid-stream: assert rst asynchronously between edges. Required response:
  - out_valid falls immediately and fetch_pc = RESET_PC.
  - The sequence restarts at pc 0 after release.
